// File: rtl/nexus_ifetch_queue.sv
// Instruction fetch queue: issues one memory request at a time under a credit limit,
// buffers in-order responses for the core, and discards in-flight fetches on a flush.
module nexus_ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [31:0]   afifo_q [DEPTH];
  logic [PW-1:0] af_wr_q, af_rd_q;

  logic [31:0]   qpc_q    [DEPTH];
  logic [31:0]   qinstr_q [DEPTH];
  logic [PW-1:0] q_wr_q, q_rd_q;

  logic [CW:0]   used;
  logic          pc_fire, gnt_fire, q_push, q_pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^pc_i[1:0];

  // Credits are what is left after counting buffered entries and every response still owed.
  assign used       = {1'b0, occ_q} + {1'b0, outst_q};
  assign pc_ready_o = rst_n && (state_q == IDLE) && !flush_i && (disc_q == '0) && (used < DEPTH_C);
  assign pc_fire    = pc_valid_i && pc_ready_o;

  assign mem_req_o  = (state_q == REQ) || (state_q == FLUSH);
  assign mem_addr_o = addr_q;
  assign gnt_fire   = mem_req_o && mem_gnt_i;

  assign instr_valid_o = (occ_q != '0);
  assign instr_o       = qinstr_q[q_rd_q];
  assign instr_pc_o    = qpc_q[q_rd_q];

  assign q_push = mem_rvalid_i && (disc_q == '0) && !flush_i;
  assign q_pop  = instr_valid_o && instr_ready_i && !flush_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (pc_fire) begin
          state_d = REQ;
          addr_d  = {pc_i[31:2], 2'b00};
        end
      end
      REQ: begin
        if (mem_gnt_i)    state_d = IDLE;
        else if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush marks every response still owed (including one granted this cycle) for discard.
  always_comb begin
    outst_d = outst_q + CW'(gnt_fire) - CW'(mem_rvalid_i);
    occ_d   = flush_i ? '0 : (occ_q + CW'(q_push) - CW'(q_pop));
    if (flush_i)
      disc_d = outst_d;
    else
      disc_d = disc_q + CW'(gnt_fire && (state_q == FLUSH))
                      - CW'(mem_rvalid_i && (disc_q != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      occ_q   <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      af_wr_q <= '0;
      af_rd_q <= '0;
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qpc_q[i]    <= '0;
        qinstr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      if (gnt_fire)     af_wr_q <= af_wr_q + 1'b1;
      if (mem_rvalid_i) af_rd_q <= af_rd_q + 1'b1;
      if (flush_i) begin
        q_wr_q <= '0;
        q_rd_q <= '0;
      end else begin
        if (q_push) begin
          qpc_q[q_wr_q]    <= afifo_q[af_rd_q];
          qinstr_q[q_wr_q] <= mem_rdata_i;
          q_wr_q           <= q_wr_q + 1'b1;
        end
        if (q_pop) q_rd_q <= q_rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_fire) afifo_q[af_wr_q] <= addr_q;
  end

  // The credit rule makes a response into a full queue impossible.
  queueNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && !q_pop && (occ_q == FULL_C)));

endmodule

// File: tb/tb_nexus_ifetch_queue.sv
// Directed bench for nexus_ifetch_queue: drivers push expected head entries into a
// scoreboard that a separate monitor drains whenever the core side consumes an entry.
module tb_nexus_ifetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  expEntry_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  nexus_ifetch_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .flush_i       (flush_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issuePc(input logic [31:0] pc);
    pc_i       = pc;
    pc_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("pc_ready_on_issue", 32'(pc_ready_o), 32'h1);
    tick();
    pc_valid_i = 1'b0;
  endtask

  task automatic grantReq(input logic [31:0] expAddr);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("mem_req_at_grant", 32'(mem_req_o), 32'h1);
    checkOutput("mem_addr_at_grant", mem_addr_o, expAddr);
    tick();
    mem_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] expPc, input bit keep);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    if (keep) expQ.push_back('{pc: expPc, instr: data});
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  // One complete fetch: accept, grant the cycle after, respond the cycle after that.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] expAddr,
                               input logic [31:0] data, input bit keep);
    issuePc(pc);
    grantReq(expAddr);
    respond(data, expAddr, keep);
  endtask

  // Monitor: every consumed head entry must match the oldest scoreboard entry.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid_o && instr_ready_i) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_instr: got pc 0x%08h instr 0x%08h, expected no entry",
                   instr_pc_o, instr_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("instr_o", instr_o, e.instr);
          checkOutput("instr_pc_o", instr_pc_o, e.pc);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    pc_i          = '0;
    pc_valid_i    = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    flush_i       = 1'b0;
    instr_ready_i = 1'b1;

    @(negedge clk);
    checkOutput("reset_pc_ready", 32'(pc_ready_o), 32'h0);
    checkOutput("reset_mem_req", 32'(mem_req_o), 32'h0);
    checkOutput("reset_instr_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset_instr", instr_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single fetch");
    applyStimulus(32'h100, 32'h100, 32'h00000013, 1'b1);
    @(negedge clk);
    checkOutput("single_valid_cycle4", 32'(instr_valid_o), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("single_valid_after_pop", 32'(instr_valid_o), 32'h0);
    tick();

    $display("[TB] alignment");
    applyStimulus(32'h203, 32'h200, 32'h0000DEAD, 1'b1);
    tick();

    $display("[TB] fill");
    instr_ready_i = 1'b0;
    applyStimulus(32'h300, 32'h300, 32'hA0000001, 1'b1);
    applyStimulus(32'h304, 32'h304, 32'hA0000002, 1'b1);
    applyStimulus(32'h308, 32'h308, 32'hA0000003, 1'b1);
    applyStimulus(32'h30C, 32'h30C, 32'hA0000004, 1'b1);
    @(negedge clk);
    checkOutput("full_pc_ready", 32'(pc_ready_o), 32'h0);
    checkOutput("full_instr_valid", 32'(instr_valid_o), 32'h1);
    tick();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("pc_ready_after_one_pop", 32'(pc_ready_o), 32'h1);
    tick();
    instr_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("drained_instr_valid", 32'(instr_valid_o), 32'h0);
    tick();

    $display("[TB] flush with two outstanding");
    instr_ready_i = 1'b0;
    applyStimulus(32'h400, 32'h400, 32'h11111111, 1'b0);
    issuePc(32'h404);
    grantReq(32'h404);
    issuePc(32'h408);
    grantReq(32'h408);
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("pc_ready_during_flush", 32'(pc_ready_o), 32'h0);
    tick();
    flush_i = 1'b0;
    instr_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_empties_queue", 32'(instr_valid_o), 32'h0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD00001;
    @(negedge clk);
    checkOutput("pc_ready_discard2", 32'(pc_ready_o), 32'h0);
    tick();
    mem_rdata_i  = 32'hBAD00002;
    @(negedge clk);
    checkOutput("pc_ready_discard1", 32'(pc_ready_o), 32'h0);
    checkOutput("drop1_instr_valid", 32'(instr_valid_o), 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("drop2_instr_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("pc_ready_after_drops", 32'(pc_ready_o), 32'h1);
    tick();

    $display("[TB] flush in REQ without grant");
    issuePc(32'h500);
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("req_flush_mem_req", 32'(mem_req_o), 32'h1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_state_mem_req", 32'(mem_req_o), 32'h1);
    checkOutput("flush_state_mem_addr", mem_addr_o, 32'h500);
    checkOutput("flush_state_pc_ready", 32'(pc_ready_o), 32'h0);
    tick();
    grantReq(32'h500);
    @(negedge clk);
    checkOutput("post_grant_mem_req", 32'(mem_req_o), 32'h0);
    checkOutput("post_grant_pc_ready", 32'(pc_ready_o), 32'h0);
    tick();
    respond(32'hBAD00003, 32'h500, 1'b0);
    @(negedge clk);
    checkOutput("flush_drop_instr_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("flush_back_to_idle", 32'(pc_ready_o), 32'h1);
    tick();

    $display("[TB] reset mid-fetch");
    instr_ready_i = 1'b0;
    applyStimulus(32'h600, 32'h600, 32'hC0000001, 1'b0);
    applyStimulus(32'h604, 32'h604, 32'hC0000002, 1'b0);
    applyStimulus(32'h608, 32'h608, 32'hC0000003, 1'b0);
    issuePc(32'h60C);
    grantReq(32'h60C);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_instr_valid", 32'(instr_valid_o), 32'h0);
    checkOutput("async_rst_instr", instr_o, 32'h0);
    checkOutput("async_rst_instr_pc", instr_pc_o, 32'h0);
    checkOutput("async_rst_pc_ready", 32'(pc_ready_o), 32'h0);
    checkOutput("async_rst_mem_req", 32'(mem_req_o), 32'h0);
    checkOutput("async_rst_mem_addr", mem_addr_o, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    applyStimulus(32'h700, 32'h700, 32'h0000ABCD, 1'b1);
    @(negedge clk);
    checkOutput("post_reset_valid", 32'(instr_valid_o), 32'h1);
    tick();
    tick();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nexus_ifetch_queue.md
NEXUS_IFETCH_QUEUE -- requirements
Module: nexus_ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries and the maximum credits (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pc_i, input, 32 bits: fetch address from the core.
REQ-005 SHALL have port pc_valid_i, input, 1 bit: pc_i is valid.
REQ-006 SHALL have port pc_ready_o, output, 1 bit: the block accepts pc_i this cycle.
REQ-007 SHALL have port mem_req_o, output, 1 bit: instruction memory request.
REQ-008 SHALL have port mem_addr_o, output, 32 bits: request address.
REQ-009 SHALL have port mem_gnt_i, input, 1 bit: the memory accepts the request.
REQ-010 SHALL have port mem_rvalid_i, input, 1 bit: response data is valid.
REQ-011 SHALL have port mem_rdata_i, input, 32 bits: response instruction word.
REQ-012 SHALL have port flush_i, input, 1 bit: discard all queued and in-flight fetches.
REQ-013 SHALL have port instr_o, output, 32 bits: instruction at the queue head, driven to the core instr_i.
REQ-014 SHALL have port instr_pc_o, output, 32 bits: fetch address of instr_o.
REQ-015 SHALL have port instr_valid_o, output, 1 bit: the queue head is valid.
REQ-016 SHALL have port instr_ready_i, input, 1 bit: the core consumes the head.

Function
REQ-017 SHALL implement an FSM with states IDLE, REQ and FLUSH.
REQ-018 SHALL assert pc_ready_o only in IDLE, with no flush_i, and with credits > 0, where credits = DEPTH - (queue occupancy + outstanding responses).
REQ-019 On pc_valid_i && pc_ready_o, SHALL latch {pc_i[31:2],2'b00} and go to REQ next cycle.
REQ-020 In REQ, SHALL assert mem_req_o with mem_addr_o held stable until mem_gnt_i.
REQ-021 On mem_gnt_i in REQ, SHALL increment the outstanding count, push the address into an internal DEPTH-entry address FIFO, and return to IDLE.
REQ-022 SHALL assume in-order responses arriving no earlier than the cycle after the grant; each mem_rvalid_i pops the address FIFO.
REQ-023 On a non-discarded mem_rvalid_i, SHALL write {popped address, mem_rdata_i} into the instruction queue; the entry is visible on instr_valid_o the next cycle.
REQ-024 Minimum latency SHALL be: grant in cycle N, rvalid in N+1, instr_valid_o in N+2.
REQ-025 SHALL drive instr_valid_o = queue not empty, with instr_o and instr_pc_o taken from the registered head entry.
REQ-026 SHALL pop the head on instr_valid_o && instr_ready_i; push and pop in the same cycle leaves occupancy unchanged.
REQ-027 Occupancy and outstanding count SHALL each be clog2(DEPTH)+1 bits; FIFO pointers SHALL wrap modulo DEPTH.
REQ-028 The credit rule SHALL guarantee that a response never arrives while the queue is full; an overflow SHALL be treated as a design error covered by an assertion.
REQ-029 On flush_i in any state, SHALL empty the queue next cycle (instr_valid_o=0) and set the discard count to the outstanding count, plus one if mem_gnt_i occurs that cycle.
REQ-030 Flush SHALL win over a simultaneous pop or push, and a flush pc_valid_i SHALL NOT be accepted in the same cycle.
REQ-031 On flush_i in REQ without mem_gnt_i, SHALL go to FLUSH, hold mem_req_o until grant, count that grant as discarded, then return to IDLE.
REQ-032 SHALL drop mem_rvalid_i responses while the discard count > 0, decrementing the discard count and the outstanding count on each.
REQ-033 SHALL NOT raise pc_ready_o while the discard count > 0.

Reset
REQ-034 While rst_n=0, SHALL asynchronously force state=IDLE, pointers, occupancy, outstanding and discard counts to 0, mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0 and pc_ready_o=0.
REQ-035 Reset during an outstanding request SHALL abandon it; the memory is reset by the same rst_n.

Verification
REQ-036 Bench SHALL check single fetch: pc_i=0x100, gnt in cycle 2, rvalid in cycle 3 with 0x00000013 -> cycle 4 shows instr_valid_o=1, instr_o=0x13, instr_pc_o=0x100.
REQ-037 Bench SHALL check fill: instr_ready_i=0 with 4 fetches completed -> pc_ready_o=0 and occupancy=4; one pop -> pc_ready_o=1 next cycle.
REQ-038 Bench SHALL check alignment: pc_i=0x203 -> mem_addr_o=0x200 and instr_pc_o=0x200.
REQ-039 Bench SHALL check flush with 2 outstanding: the next 2 rvalids are dropped, instr_valid_o stays 0, and pc_ready_o returns after the second.
REQ-040 Bench SHALL check flush in REQ without gnt: mem_req_o holds to grant, the response is dropped, then IDLE.
REQ-041 Bench SHALL check reset mid-fetch: rst_n low with 3 entries plus 1 outstanding -> all outputs 0 immediately and a clean fetch after release.
